// File: rtl/univ_reg_n.sv
// Universal WIDTH-bit register: clear/set, load, shift, rotate, up/down count.
// Registered carry/shift-out flag and combinational terminal-count flag.
module univ_reg_n #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tc
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    mode_e            op;
    logic             all_ones;
    logic             all_zero;
    logic [WIDTH-1:0] q_nx;
    logic             co_nx;

    assign op       = mode_e'(mode);
    assign all_ones = &q;
    assign all_zero = ~|q;

    // tc looks only at q and mode so it can gate the next stage this cycle
    assign tc = ((op == M_INC) && all_ones) ||
                ((op == M_DEC) && all_zero);

    always_comb begin
        q_nx  = q;
        co_nx = co;
        case (op)
            M_HOLD: begin
                q_nx  = q;
                co_nx = co;
            end
            M_LOAD: q_nx = d;
            M_SHL: begin
                q_nx  = {q[WIDTH-2:0], sin};
                co_nx = q[WIDTH-1];
            end
            M_SHR: begin
                q_nx  = {sin, q[WIDTH-1:1]};
                co_nx = q[0];
            end
            M_ROL: begin
                q_nx  = {q[WIDTH-2:0], q[WIDTH-1]};
                co_nx = q[WIDTH-1];
            end
            M_ROR: begin
                q_nx  = {q[0], q[WIDTH-1:1]};
                co_nx = q[0];
            end
            M_INC: begin
                q_nx  = q + 1'b1;
                co_nx = all_ones;
            end
            M_DEC: begin
                q_nx  = q - 1'b1;
                co_nx = all_zero;
            end
            default: begin
                q_nx  = q;
                co_nx = co;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q  <= '0;
            co <= 1'b0;
        end else if (set) begin
            q  <= SET_VALUE;
            co <= 1'b0;
        end else if (en) begin
            q  <= q_nx;
            co <= co_nx;
        end
    end

endmodule

// File: tb/tb_univ_reg_n.sv
// Directed self-checking bench for univ_reg_n (WIDTH=8, SET_VALUE=8'hFF).
// Linear stimulus with hand-computed expected values.
module tb_univ_reg_n;

    logic       clk = 1'b0;
    logic       clr, set, en, sin;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       co, tc;

    int checks   = 0;
    int failures = 0;

    univ_reg_n #(.WIDTH(8), .SET_VALUE(8'hFF)) dut (
        .clk (clk),
        .clr (clr),
        .set (set),
        .en  (en),
        .mode(mode),
        .d   (d),
        .sin (sin),
        .q   (q),
        .co  (co),
        .tc  (tc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq,
                           input logic eco, input logic etc);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".co"}, {7'b0, co}, {7'b0, eco});
        chk({tag, ".tc"}, {7'b0, tc}, {7'b0, etc});
    endtask

    initial begin
        clr = 1'b1; set = 1'b1; en = 1'b1;
        mode = 3'b001; d = 8'hA5; sin = 1'b0;
        step();
        chk_all("rst_clr_over_set", 8'h00, 1'b0, 1'b0);

        clr = 1'b0;
        step();
        chk_all("set", 8'hFF, 1'b0, 1'b0);

        set = 1'b0; en = 1'b0;
        step();
        chk_all("en0_hold", 8'hFF, 1'b0, 1'b0);

        en = 1'b1; mode = 3'b001; d = 8'hB4;
        step();
        chk_all("load_b4", 8'hB4, 1'b0, 1'b0);

        mode = 3'b010; d = 8'h00;
        sin = 1'b1; step(); chk_all("shl1", 8'h69, 1'b1, 1'b0);
        sin = 1'b0; step(); chk_all("shl2", 8'hD2, 1'b0, 1'b0);
        sin = 1'b1; step(); chk_all("shl3", 8'hA5, 1'b1, 1'b0);
        sin = 1'b1; step(); chk_all("shl4", 8'h4B, 1'b1, 1'b0);

        mode = 3'b001; d = 8'h81;
        step(); chk_all("load_81", 8'h81, 1'b1, 1'b0);
        mode = 3'b011; sin = 1'b0;
        step(); chk_all("shr", 8'h40, 1'b1, 1'b0);

        mode = 3'b001; d = 8'h81;
        step(); chk_all("load_81b", 8'h81, 1'b1, 1'b0);
        mode = 3'b100; sin = 1'b0;
        step(); chk_all("rol", 8'h03, 1'b1, 1'b0);
        mode = 3'b101; sin = 1'b0;
        step(); chk_all("ror1", 8'h81, 1'b1, 1'b0);
        step(); chk_all("ror2", 8'hC0, 1'b1, 1'b0);

        mode = 3'b000; d = 8'h00; sin = 1'b1;
        step(); chk_all("mode_hold", 8'hC0, 1'b1, 1'b0);

        mode = 3'b001; d = 8'hFE;
        step(); chk_all("load_fe", 8'hFE, 1'b1, 1'b0);
        mode = 3'b110;
        #1; chk_all("inc_pre", 8'hFE, 1'b1, 1'b0);
        step(); chk_all("inc_ff", 8'hFF, 1'b0, 1'b1);
        step(); chk_all("inc_wrap", 8'h00, 1'b1, 1'b0);
        mode = 3'b111;
        #1; chk_all("dec_tc_comb", 8'h00, 1'b1, 1'b1);
        step(); chk_all("dec_wrap", 8'hFF, 1'b1, 1'b0);

        clr = 1'b1;
        step(); chk_all("clr_mid", 8'h00, 1'b0, 1'b1);
        clr = 1'b0; en = 1'b0;
        step(); chk_all("tc_en0", 8'h00, 1'b0, 1'b1);

        en = 1'b1; mode = 3'b001; d = 8'h10;
        step(); chk_all("load_10", 8'h10, 1'b0, 1'b0);
        mode = 3'b110;
        en = 1'b1; step(); chk_all("gate1", 8'h11, 1'b0, 1'b0);
        en = 1'b0; step(); chk_all("gate2", 8'h11, 1'b0, 1'b0);
        en = 1'b1; step(); chk_all("gate3", 8'h12, 1'b0, 1'b0);
        en = 1'b0; step(); chk_all("gate4", 8'h12, 1'b0, 1'b0);

        en = 1'b1; set = 1'b1;
        step(); chk_all("set_over_inc", 8'hFF, 1'b0, 1'b1);
        set = 1'b0;

        mode = 3'b001; d = 8'h05;
        step(); chk_all("load_05", 8'h05, 1'b0, 1'b0);
        mode = 3'b110;
        step(); chk_all("cnt1", 8'h06, 1'b0, 1'b0);
        step(); chk_all("cnt2", 8'h07, 1'b0, 1'b0);
        step(); chk_all("cnt3", 8'h08, 1'b0, 1'b0);
        clr = 1'b1;
        step(); chk_all("clr_cnt", 8'h00, 1'b0, 1'b0);
        clr = 1'b0;
        step(); chk_all("resume", 8'h01, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/univ_reg_n.md
# univ_reg_n

Parameterised universal register, the next generation of the team's single-bit set/clear flip-flop. It stores a WIDTH-bit word with synchronous clear and set, and adds parallel load, shift, rotate and up/down count modes under an enable. A registered carry/shift-out flag and a combinational terminal-count flag are provided. It serves as the common datapath register for counters, serial links and shift-based arithmetic in later labs.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- SET_VALUE, {WIDTH{1'b1}}, value loaded by `set`

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous, active-high reset/clear
- set  input  1  synchronous, active-high preset to SET_VALUE
- en  input  1  operation enable; when 0, q and co hold
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin  input  1  serial input for shift modes
- q  output  WIDTH  registered state
- co  output  1  registered carry / borrow / shifted-out bit
- tc  output  1  combinational terminal count

## Operation
- Priority at each rising clk edge: clr > set > en-gated mode > hold.
- clr=1: q<=0, co<=0, regardless of set, en, mode.
- clr=0, set=1: q<=SET_VALUE, co<=0.
- clr=0, set=0, en=0: q, co hold.
- clr=0, set=0, en=1, by mode:
  - 000 hold: q, co unchanged.
  - 001 load: q<=d; co unchanged.
  - 010 shift left: q<={q[WIDTH-2:0], sin}; co<=q[WIDTH-1].
  - 011 shift right: q<={sin, q[WIDTH-1:1]}; co<=q[0].
  - 100 rotate left: q<={q[WIDTH-2:0], q[WIDTH-1]}; co<=q[WIDTH-1].
  - 101 rotate right: q<={q[0], q[WIDTH-1:1]}; co<=q[0].
  - 110 increment: q<=q+1 modulo 2^WIDTH; co<=1 iff q was all ones (wrap), else 0.
  - 111 decrement: q<=q-1 modulo 2^WIDTH; co<=1 iff q was 0 (borrow/wrap), else 0.
- Arithmetic is unsigned, WIDTH bits, with no saturation. Wrap-around is the required behaviour.
- tc (combinational from q and mode, independent of en):
  - 1 when mode=110 and q is all ones.
  - 1 when mode=111 and q=0.
  - 0 in all other modes.
- sin is ignored except in modes 010/011.
- d is ignored except in mode 001.

## Timing
- Single clock domain. All state changes occur only on rising clk; there is no asynchronous path.
- Latency: one cycle from inputs sampled at edge N to new q/co visible after edge N.
- tc has zero-cycle latency. It is valid in the same cycle as q/mode and is intended for use as the next-stage enable.
- Reset value: q=0, co=0. tc=0 after reset unless mode=111, since q=0 then gives tc=1.
- clr asserted mid-operation (any mode, any en) takes effect at the next edge and overrides set.
- clr and set both high: clr wins (q=0).
- set with en=1 and any mode: set wins; the mode operation is discarded that cycle.
- Mode may change every cycle. Each edge uses only the mode present at that edge; there is no internal pipeline or sequencing state.

## Test plan
Concrete values use WIDTH=8, SET_VALUE=8'hFF.
- Reset/priority: drive clr=1, set=1, en=1, mode=001, d=8'hA5 for 1 edge -> q=8'h00, co=0. Drop clr, keep set=1 -> q=8'hFF, co=0. Drop set, en=0 -> q holds 8'hFF.
- Load and shift: load 8'hB4 (mode 001). Then 4 edges of mode 010 with sin=1,0,1,1 -> q=8'h4B; co after each edge: 1,0,1,1.
- Shift right and rotate: load 8'h81. Mode 011 with sin=0 -> q=8'h40, co=1. Load 8'h81 again. Mode 100 -> q=8'h03, co=1. Mode 101 twice -> q=8'h81 then 8'hC0, co=1 then 1.
- Count wrap: load 8'hFE. Mode 110: tc=0, then after the edge q=8'hFF, co=0, tc=1. Next edge -> q=8'h00, co=1, tc=0. Switch to mode 111 -> tc=1 immediately. Next edge -> q=8'hFF, co=1.
- Enable gating: q=8'h10, mode=110, en toggling 1,0,1,0 over 4 edges -> q=8'h11,8'h11,8'h12,8'h12; co stays 0.
- Reset mid-count: increment from 8'h05 for 3 edges (q=8'h08), then assert clr for 1 edge while en=1 -> q=8'h00, co=0. Deassert clr -> counting resumes at 8'h01 on the next edge.
